axi_addr_qos_arbiter: RTL

- Arbitration and scheduling controller for the shared AXI address path of a fabric crossbar.
- Chooses which of REQ_N buffered slave-side address requests drives the address mux and master select.
- Grant order: QoS priority first, then round-robin among equals, with anti-starvation aging.
- Enforces a per-requester outstanding-transaction limit. Holds each grant until the downstream address handshake completes.

---
 rtl/axi_addr_qos_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axi_addr_qos_arbiter.sv
// QoS-priority arbiter for the shared AXI address path: round-robin among equal
// QoS, age-based promotion, per-requester outstanding limits, grant held until handshake.
module axi_addr_qos_arbiter #(
    parameter int unsigned REQ_N      = 4,
    parameter int unsigned QOS_WIDTH  = 4,
    parameter int unsigned MAX_OUTST  = 8,
    parameter int unsigned AGE_THRESH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [REQ_N-1:0]             req,
    input  logic [REQ_N*QOS_WIDTH-1:0]   req_qos,
    input  logic                         addr_hs,
    input  logic [REQ_N-1:0]             rsp_done,
    output logic [REQ_N-1:0]             grant,
    output logic [$clog2(REQ_N)-1:0]     grant_index,
    output logic                         grant_valid,
    output logic [REQ_N-1:0]             outst_full,
    output logic                         err_underflow
);

    localparam int unsigned IDX_W = $clog2(REQ_N);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned AGE_W = $clog2(AGE_THRESH + 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t               r_state, w_state_nxt;
    logic [REQ_N-1:0]     r_grant, w_grant_nxt;
    logic [IDX_W-1:0]     r_grant_index, w_grant_index_nxt;
    logic                 r_grant_valid, w_grant_valid_nxt;
    logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic                 w_accept;
    logic                 r_err;
    logic [CNT_W-1:0]     r_outst [REQ_N];
    logic [AGE_W-1:0]     r_age   [REQ_N];
    logic [REQ_N-1:0]     w_full;
    logic [REQ_N-1:0]     w_elig;
    logic [QOS_WIDTH-1:0] w_eff_qos [REQ_N];
    logic [QOS_WIDTH-1:0] w_win_qos;
    logic [IDX_W-1:0]     w_win_idx;
    logic [IDX_W-1:0]     w_scan;
    logic                 w_win_found;

    // Eligibility and effective QoS; a requester that has aged out jumps to top priority
    always_comb begin
        for (int unsigned i = 0; i < REQ_N; i++) begin
            w_full[i]    = (r_outst[i] == CNT_W'(MAX_OUTST));
            w_elig[i]    = req[i] & ~w_full[i];
            w_eff_qos[i] = (r_age[i] == AGE_W'(AGE_THRESH)) ? '1
                                                            : req_qos[i*QOS_WIDTH +: QOS_WIDTH];
        end
    end

    // Scan from rr_ptr+1; strict '>' keeps the first index found among equal QoS
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_win_qos   = '0;
        w_scan      = '0;
        for (int unsigned k = 1; k <= REQ_N; k++) begin
            w_scan = IDX_W'((32'(r_rr_ptr) + k) % REQ_N);
            if (w_elig[w_scan] && (!w_win_found || (w_eff_qos[w_scan] > w_win_qos))) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan;
                w_win_qos   = w_eff_qos[w_scan];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_index <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= IDX_W'(REQ_N - 1);
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_index <= w_grant_index_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_index_nxt = r_grant_index;
        w_grant_valid_nxt = r_grant_valid;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_accept          = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt       = S_GRANT;
                    w_grant_nxt       = REQ_N'(1) << w_win_idx;
                    w_grant_index_nxt = w_win_idx;
                    w_grant_valid_nxt = 1'b1;
                end
            end
            S_GRANT: begin
                if (addr_hs) begin
                    w_accept          = 1'b1;
                    w_state_nxt       = S_IDLE;
                    w_grant_nxt       = '0;
                    w_grant_index_nxt = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_rr_ptr_nxt      = r_grant_index;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outstanding counters and aging; a simultaneous issue and completion cancel out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
            for (int unsigned i = 0; i < REQ_N; i++) begin
                r_outst[i] <= '0;
                r_age[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < REQ_N; i++) begin
                if (w_accept && (r_grant_index == IDX_W'(i)) && !rsp_done[i]) begin
                    r_outst[i] <= r_outst[i] + CNT_W'(1);
                end else if (rsp_done[i] && !(w_accept && (r_grant_index == IDX_W'(i)))) begin
                    if (r_outst[i] == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_outst[i] <= r_outst[i] - CNT_W'(1);
                    end
                end

                if (w_accept && (r_grant_index == IDX_W'(i))) begin
                    r_age[i] <= '0;
                end else if (!w_elig[i]) begin
                    r_age[i] <= '0;
                end else if (r_grant_valid && (r_grant_index == IDX_W'(i))) begin
                    r_age[i] <= r_age[i];
                end else if (r_age[i] != AGE_W'(AGE_THRESH)) begin
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
        end
    end

    assign grant         = r_grant;
    assign grant_index   = r_grant_index;
    assign grant_valid   = r_grant_valid;
    assign outst_full    = w_full;
    assign err_underflow = r_err;

endmodule
